// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch controller.
// FSM encoding and BCD digit limits.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One BCD decade digit with sync clear and ripple carry.
// Out-of-range codes fall back to 0 on the next increment.
module bcd_digit
    import stopwatch_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] q,
    output logic               carry_out
);

    // Carry ripples combinationally into the next digit.
    assign carry_out = inc & (q == BCD_MAX);

    // Digit register: clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            if (q >= BCD_MAX) begin
                q <= '0;
            end else begin
                q <= q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/clear stopwatch with lap capture.
// Owns the FSM, prescaler, overflow flag and lap register.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      clear,
    input  logic                      lap,
    output logic [DIGIT_W*DIGITS-1:0] cnt,
    output logic                      running,
    output logic                      overflow,
    output logic [DIGIT_W*DIGITS-1:0] lap_cnt,
    output logic                      lap_valid
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_TOP = PW'(PRESCALE - 1);

    state_t        state;
    logic [PW-1:0] presc;
    logic          at_top;
    logic          tick_go;
    logic [DIGITS:0] carry;

    // Tick only when a running cycle is not overridden by stop/clear.
    assign at_top   = (presc == P_TOP);
    assign tick_go  = (state == RUN) & at_top & ~stop & ~clear;
    assign carry[0] = tick_go;

    // Digit chain: each digit increments on the carry of the one below.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_digit u_dig (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (clear),
            .inc       (carry[g]),
            .q         (cnt[g*DIGIT_W +: DIGIT_W]),
            .carry_out (carry[g+1])
        );
    end

    // FSM with prescaler, overflow and lap capture; clear > stop > start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            running   <= 1'b0;
            presc     <= '0;
            overflow  <= 1'b0;
            lap_cnt   <= '0;
            lap_valid <= 1'b0;
        end else begin
            if (lap && (state != IDLE)) begin
                lap_cnt   <= cnt;
                lap_valid <= 1'b1;
            end else begin
                lap_valid <= 1'b0;
            end

            if (clear) begin
                state    <= IDLE;
                running  <= 1'b0;
                presc    <= '0;
                overflow <= 1'b0;
            end else if (stop) begin
                if (state == RUN) begin
                    state   <= PAUSE;
                    running <= 1'b0;
                end
            end else if (start && (state != RUN)) begin
                state   <= RUN;
                running <= 1'b1;
                if (state == IDLE) begin
                    presc <= '0;
                end
            end else if (state == RUN) begin
                presc <= at_top ? '0 : presc + 1'b1;
                if (carry[DIGITS]) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule
